// File: rtl/data_sram_responder_pkg.sv
// rtl/data_sram_responder_pkg.sv - shared state codes and helpers for the data-SRAM responder
//
// Purpose: FSM state encodings and the wait-counter width used by
// data_sram_responder. No ports.

package data_sram_responder_pkg;

  localparam logic [1:0] DSRAM_IDLE = 2'd0;
  localparam logic [1:0] DSRAM_WAIT = 2'd1;
  localparam logic [1:0] DSRAM_RESP = 2'd2;

  localparam int DSRAM_WAIT_WD = 4;

  // Counter preload for an access with n wait states: the WAIT state is
  // left on the edge where the counter reads zero, so it starts at n-1.
  function automatic logic [DSRAM_WAIT_WD-1:0] wait_load(input int n);
    return (n > 0) ? DSRAM_WAIT_WD'(n - 1) : '0;
  endfunction

endpackage

// File: rtl/data_sram_responder_dsram_bank.sv
// rtl/data_sram_responder_dsram_bank.sv - four byte-lane data memory with registered read port
//
// Purpose: 2**ADDR_W x 32-bit storage split into four 8-bit lanes.
// Writes are synchronous with a per-lane enable. Reads register the addressed
// word into rdata only when re is set, so rdata holds between reads.
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset (clears rdata, blocks writes)
//   we     in   per-lane write enables
//   addr   in   word address
//   wdata  in   lane-aligned write data
//   re     in   load rdata from addr on this edge
//   rdata  out  registered read word

module dsram_bank #(
  parameter int ADDR_W    = 14,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              re,
  output logic [31:0]       rdata
);

  logic [31:0] rword;
  logic [31:0] rdata_d;
  logic [31:0] rdata_q;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
      if (!rst && we[i]) begin
        mem[addr] <= wdata[8*i +: 8];
      end
    end

    assign rword[8*i +: 8] = mem[addr];
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rst) begin
      rdata_d = '0;
    end else if (re) begin
      rdata_d = rword;
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - CPU data-SRAM responder with programmable wait states
//
// Purpose: serves EX-stage loads/stores from a byte-writable word memory and
// returns the read word to MEM one cycle after the access completes. With
// WAIT_CYCLES>0 each access is stretched and stallreq holds the pipeline.
// Ports:
//   clk              in   system clock
//   rst              in   synchronous active-high reset
//   data_sram_en     in   request valid
//   data_sram_wen    in   byte write enables, 0 = read
//   data_sram_addr   in   byte address, bits [ADDR_W+1:2] used
//   data_sram_wdata  in   lane-aligned store data
//   data_sram_rdata  out  read word, held until the next read completes
//   stallreq         out  pipeline hold request

module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int WAIT_CYCLES = 0,
  parameter     INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq
);

  localparam logic [DSRAM_WAIT_WD-1:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

  logic [1:0]               state_q, state_d;
  logic [DSRAM_WAIT_WD-1:0] wait_cnt_q, wait_cnt_d;
  logic                     req_en_q, req_en_d;
  logic [3:0]               req_wen_q, req_wen_d;
  logic [ADDR_W-1:0]        req_word_q, req_word_d;
  logic [31:0]              req_wdata_q, req_wdata_d;

  logic                     accept;
  logic [3:0]               bank_we;
  logic                     bank_re;
  logic [ADDR_W-1:0]        bank_addr;
  logic [31:0]              bank_wdata;
  logic [ADDR_W-1:0]        in_word;
  logic                     unused_addr_bits;

  // Upper bits alias and the byte offset is checked upstream.
  assign in_word          = data_sram_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  // RESP accepts like IDLE; only WAIT blocks new requests.
  assign accept = data_sram_en && (state_q != DSRAM_WAIT);

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    req_en_d    = req_en_q;
    req_wen_d   = req_wen_q;
    req_word_d  = req_word_q;
    req_wdata_d = req_wdata_q;
    bank_we     = 4'b0000;
    bank_re     = 1'b0;
    bank_addr   = in_word;
    bank_wdata  = data_sram_wdata;

    if (accept) begin
      req_en_d    = 1'b1;
      req_wen_d   = data_sram_wen;
      req_word_d  = in_word;
      req_wdata_d = data_sram_wdata;
      if (WAIT_CYCLES == 0) begin
        bank_we = data_sram_wen;
        bank_re = (data_sram_wen == 4'b0000);
        state_d = DSRAM_RESP;
      end else begin
        state_d    = DSRAM_WAIT;
        wait_cnt_d = WAIT_LOAD;
      end
    end else if (state_q == DSRAM_WAIT) begin
      // Inputs may wander while stalled; only the latched request is served.
      bank_addr  = req_word_q;
      bank_wdata = req_wdata_q;
      if (wait_cnt_q == '0) begin
        bank_we = req_en_q ? req_wen_q : 4'b0000;
        bank_re = req_en_q && (req_wen_q == 4'b0000);
        state_d = DSRAM_RESP;
      end else begin
        wait_cnt_d = wait_cnt_q - 1'b1;
      end
    end else if (state_q == DSRAM_RESP) begin
      state_d = DSRAM_IDLE;
    end

    if (rst) begin
      state_d     = DSRAM_IDLE;
      wait_cnt_d  = '0;
      req_en_d    = 1'b0;
      req_wen_d   = 4'b0000;
      req_word_d  = '0;
      req_wdata_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    wait_cnt_q  <= wait_cnt_d;
    req_en_q    <= req_en_d;
    req_wen_q   <= req_wen_d;
    req_word_q  <= req_word_d;
    req_wdata_q <= req_wdata_d;
  end

  // Stall through the accept cycle and every WAIT cycle but the last, so the
  // pipeline advances exactly as the response is registered.
  assign stallreq = !rst &&
                    (((WAIT_CYCLES != 0) && data_sram_en && (state_q != DSRAM_WAIT)) ||
                     ((state_q == DSRAM_WAIT) && (wait_cnt_q != '0)));

  dsram_bank #(
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (bank_we),
    .addr  (bank_addr),
    .wdata (bank_wdata),
    .re    (bank_re),
    .rdata (data_sram_rdata)
  );

endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - randomized model-checked bench for data_sram_responder

module tb_data_sram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit done [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int N = (g == 0) ? 0 : ((g == 1) ? 2 : 3);

    logic        rst_i, en, stall;
    logic [3:0]  wen;
    logic [31:0] addr, wdata, rdata;
    logic [31:0] exp_rdata;
    logic        exp_stall;
    logic        chk_on = 1'b0;
    int          stall_cnt = 0;
    logic [31:0] mem [int unsigned];
    int unsigned pool [$];

    data_sram_responder #(
      .ADDR_W      (14),
      .WAIT_CYCLES (N),
      .INIT_FILE   ("")
    ) u_dut (
      .clk             (clk),
      .rst             (rst_i),
      .data_sram_en    (en),
      .data_sram_wen   (wen),
      .data_sram_addr  (addr),
      .data_sram_wdata (wdata),
      .data_sram_rdata (rdata),
      .stallreq        (stall)
    );

    always @(negedge clk) begin
      if (chk_on) begin
        if (stall) stall_cnt++;
        chk($sformatf("n%0d_stallreq", N), {31'b0, stall}, {31'b0, exp_stall});
        chk($sformatf("n%0d_rdata", N), rdata, exp_rdata);
      end
    end

    function automatic logic [31:0] make_addr(input int unsigned wi);
      return ($urandom & 32'hFFFF_0003) | (32'(wi) << 2);
    endfunction

    // One transaction: hold the request until the pipeline would advance,
    // then fold its effect into the model.
    task automatic access(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                          input bit perturb);
      int unsigned wi;
      wi = int'(a[15:2]);
      en = 1'b1; wen = w; addr = a; wdata = d;
      for (int k = 0; k <= N; k++) begin
        exp_stall = (N != 0) && (k < N);
        if (perturb && k > 0) begin
          addr  = make_addr(pool[$urandom_range(0, pool.size() - 1)]);
          wdata = $urandom;
        end
        @(posedge clk); #1;
      end
      en = 1'b0; wen = 4'b0000; exp_stall = 1'b0;
      if (w == 4'b0000) exp_rdata = mem[wi];
      else mem[wi] = merge(mem.exists(wi) ? mem[wi] : 32'h0, d, w);
    endtask

    initial begin
      int s0;
      rst_i = 1'b1; en = 1'b0; wen = 4'b0000; addr = '0; wdata = '0;
      exp_rdata = '0; exp_stall = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_i = 1'b0;
      chk_on = 1'b1;
      chk($sformatf("n%0d_reset_rdata", N), rdata, 32'h0);
      pool.push_back(32'h40); pool.push_back(32'h41);
      pool.push_back(32'h80); pool.push_back(32'h2);

      access(4'hF, 32'h100, 32'hDEADBEEF, 0);
      access(4'h0, 32'h100, 32'h0, 0);
      chk($sformatf("n%0d_t1", N), rdata, 32'hDEADBEEF);

      access(4'hF, 32'h104, 32'h11223344, 0);
      access(4'b0100, 32'h104, 32'h00AA0000, 0);
      access(4'h0, 32'h104, 32'h0, 0);
      chk($sformatf("n%0d_t2", N), rdata, 32'h11AA3344);

      access(4'hF, 32'h200, 32'hCAFEF00D, 0);
      s0 = stall_cnt;
      access(4'h0, 32'h200, 32'h0, 0);
      chk($sformatf("n%0d_t3_rdata", N), rdata, 32'hCAFEF00D);
      chk($sformatf("n%0d_t3_stall_cycles", N), 32'(stall_cnt - s0), 32'(N));

      access(4'hF, 32'h0001_0008, 32'h5A5A1234, 0);
      access(4'h0, 32'h0000_0008, 32'h0, 0);
      chk($sformatf("n%0d_t6_alias", N), rdata, 32'h5A5A1234);

      access(4'hF, 32'h8, 32'h77665544, 1);
      access(4'h0, 32'h104, 32'h0, 0);
      chk($sformatf("n%0d_t4_other_word", N), rdata, 32'h11AA3344);
      access(4'h0, 32'h8, 32'h0, 0);
      chk($sformatf("n%0d_t4_served", N), rdata, 32'h77665544);

      // Reset one cycle after a write is accepted: with wait states the write
      // is still pending and must be dropped.
      en = 1'b1; wen = 4'hF; addr = 32'h100; wdata = 32'h0BADF00D;
      exp_stall = (N != 0);
      @(posedge clk); #1;
      if (N == 0) mem[32'h40] = 32'h0BADF00D;
      rst_i = 1'b1; en = 1'b0; wen = 4'h0; exp_stall = 1'b0;
      @(posedge clk); #1;
      rst_i = 1'b0; exp_rdata = '0;
      chk($sformatf("n%0d_t5_rdata", N), rdata, 32'h0);
      chk($sformatf("n%0d_t5_stallreq", N), {31'b0, stall}, 32'h0);
      access(4'h0, 32'h100, 32'h0, 0);
      chk($sformatf("n%0d_t5_word", N), rdata, (N == 0) ? 32'h0BADF00D : 32'hDEADBEEF);

      for (int i = 0; i < 8; i++) begin
        int unsigned wi;
        wi = $urandom_range(0, 16383);
        pool.push_back(wi);
        access(4'hF, make_addr(wi), $urandom, 0);
      end
      for (int i = 0; i < 8; i++) begin
        access(4'h0, make_addr(pool[i + 4]), 32'h0, 0);
      end

      repeat (120) begin
        int unsigned wi;
        int op;
        logic [3:0] w;
        wi = pool[$urandom_range(0, pool.size() - 1)];
        op = $urandom_range(0, 2);
        w  = (op == 0) ? 4'h0 : ((op == 1) ? 4'hF : 4'($urandom_range(1, 14)));
        access(w, make_addr(wi), $urandom, 1'($urandom_range(0, 1)));
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      done[g] = 1'b1;
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    while (!(done[0] && done[1] && done[2]) && cyc < 30000) begin
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 30000) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=%0d cycles required=completion", cyc);
    end
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
